// File: rtl/iir_orde1_tdm_axis.sv
// Multi-channel first-order IIR on AXI4-Stream beats, one shared MAC stepping
// through the channels; shadow/commit coefficients, bypass, deferred clear.
module iir_orde1_tdm_axis #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int COEF_W   = 16,
  parameter int FRAC     = 14,
  parameter int ACC_W    = 48,
  parameter int CFG_AW   = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_CH*SAMPLE_W-1:0]   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [NUM_CH*SAMPLE_W-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  input  logic                         cfg_we,
  input  logic [CFG_AW-1:0]            cfg_addr,
  input  logic [COEF_W-1:0]            cfg_wdata,
  input  logic                         cfg_commit,
  input  logic                         ctrl_enable,
  input  logic                         ctrl_bypass,
  input  logic                         ctrl_clear,
  output logic                         commit_pending,
  output logic                         sat_sticky
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = SAMPLE_W + COEF_W;
  localparam int BW   = NUM_CH * SAMPLE_W;
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                     state_q;
  logic [BW-1:0]              din_q, dout_q;
  logic                       tlast_in_q, tlast_out_q, tvalid_q, bypass_q;
  logic                       commit_q, clear_q, sat_q;
  logic [CH_W-1:0]            ch_q;
  logic signed [COEF_W-1:0]   a0_sh_q [NUM_CH];
  logic signed [COEF_W-1:0]   a1_sh_q [NUM_CH];
  logic signed [COEF_W-1:0]   b1_sh_q [NUM_CH];
  logic signed [COEF_W-1:0]   a0_q    [NUM_CH];
  logic signed [COEF_W-1:0]   a1_q    [NUM_CH];
  logic signed [COEF_W-1:0]   b1_q    [NUM_CH];
  logic signed [SAMPLE_W-1:0] x1_q    [NUM_CH];
  logic signed [SAMPLE_W-1:0] y1_q    [NUM_CH];

  function automatic logic signed [SAMPLE_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > SMAX)      return SMAX[SAMPLE_W-1:0];
    else if (v < SMIN) return SMIN[SAMPLE_W-1:0];
    else               return v[SAMPLE_W-1:0];
  endfunction

  function automatic logic clip_fn(input logic signed [ACC_W-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  logic signed [SAMPLE_W-1:0] x_d, y_d;
  logic signed [PW-1:0]       p0_d, p1_d, p2_d;
  logic signed [ACC_W-1:0]    acc_d, ysh_d;
  logic                       clip_d, accept, do_copy, do_clear, last_ch;
  logic [CFG_AW-3:0]          cfg_ch;
  logic [1:0]                 cfg_sel;

  // Gating with aresetn keeps ready low while reset is held, whatever ctrl_enable does.
  assign s_axis_tready  = aresetn && (state_q == IDLE) && ctrl_enable;
  assign accept         = s_axis_tvalid && s_axis_tready;
  assign do_copy        = (state_q == IDLE) && commit_q;
  assign do_clear       = (state_q == IDLE) && clear_q;
  assign last_ch        = (ch_q == CH_W'(NUM_CH - 1));
  assign cfg_ch         = cfg_addr[CFG_AW-1:2];
  assign cfg_sel        = cfg_addr[1:0];
  assign m_axis_tdata   = dout_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_out_q;
  assign commit_pending = commit_q;
  assign sat_sticky     = sat_q;

  always_comb begin
    x_d   = din_q[(NUM_CH - 1 - int'(ch_q)) * SAMPLE_W +: SAMPLE_W];
    p0_d  = PW'(x_d) * PW'(a0_q[ch_q]);
    p1_d  = PW'(x1_q[ch_q]) * PW'(a1_q[ch_q]);
    p2_d  = PW'(y1_q[ch_q]) * PW'(b1_q[ch_q]);
    acc_d = ACC_W'(p0_d) + ACC_W'(p1_d) + ACC_W'(p2_d);
    ysh_d = acc_d >>> FRAC;
    if (bypass_q) begin
      y_d    = x_d;
      clip_d = 1'b0;
    end else begin
      y_d    = sat_fn(ysh_d);
      clip_d = clip_fn(ysh_d);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      din_q       <= '0;
      dout_q      <= '0;
      tlast_in_q  <= 1'b0;
      tlast_out_q <= 1'b0;
      tvalid_q    <= 1'b0;
      bypass_q    <= 1'b0;
      commit_q    <= 1'b0;
      clear_q     <= 1'b0;
      sat_q       <= 1'b0;
      ch_q        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        a0_sh_q[c] <= '0;
        a1_sh_q[c] <= '0;
        b1_sh_q[c] <= '0;
        a0_q[c]    <= '0;
        a1_q[c]    <= '0;
        b1_q[c]    <= '0;
        x1_q[c]    <= '0;
        y1_q[c]    <= '0;
      end
    end else begin
      commit_q <= cfg_commit || (commit_q && !do_copy);
      clear_q  <= ctrl_clear || (clear_q && !do_clear);
      // Copy reads the pre-write shadow; a same-cycle cfg write still lands in shadow.
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && (cfg_ch == (CFG_AW-2)'(c))) begin
          case (cfg_sel)
            2'd0:    a0_sh_q[c] <= cfg_wdata;
            2'd1:    a1_sh_q[c] <= cfg_wdata;
            2'd2:    b1_sh_q[c] <= cfg_wdata;
            default: ;
          endcase
        end
        if (do_copy) begin
          a0_q[c] <= a0_sh_q[c];
          a1_q[c] <= a1_sh_q[c];
          b1_q[c] <= b1_sh_q[c];
        end
        if (do_clear) begin
          x1_q[c] <= '0;
          y1_q[c] <= '0;
        end
      end
      if (do_clear) sat_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            din_q      <= s_axis_tdata;
            tlast_in_q <= s_axis_tlast;
            bypass_q   <= ctrl_bypass;
            ch_q       <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          dout_q[(NUM_CH - 1 - int'(ch_q)) * SAMPLE_W +: SAMPLE_W] <= y_d;
          if (!bypass_q) begin
            x1_q[ch_q] <= x_d;
            y1_q[ch_q] <= y_d;
            sat_q      <= sat_q || clip_d;
          end
          if (last_ch) begin
            tvalid_q    <= 1'b1;
            tlast_out_q <= tlast_in_q;
            state_q     <= OUT;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            tvalid_q    <= 1'b0;
            tlast_out_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_orde1_tdm_axis.sv
// Directed bench for iir_orde1_tdm_axis (two channels, Q2.14 coefficients).
module tb_iir_orde1_tdm_axis;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, m_tready;
  logic        s_axis_tready, m_axis_tvalid, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        cfg_we, cfg_commit, ctrl_enable, ctrl_bypass, ctrl_clear;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        commit_pending, sat_sticky;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  iir_orde1_tdm_axis #(
    .NUM_CH(2), .SAMPLE_W(16), .COEF_W(16), .FRAC(14), .ACC_W(48), .CFG_AW(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_axis_tlast),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .ctrl_enable(ctrl_enable), .ctrl_bypass(ctrl_bypass), .ctrl_clear(ctrl_clear),
    .commit_pending(commit_pending), .sat_sticky(sat_sticky)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input int ch, input int sel, input logic signed [15:0] val);
    @(negedge aclk);
    cfg_we    = 1'b1;
    cfg_addr  = {ch[5:0], sel[1:0]};
    cfg_wdata = val;
    @(negedge aclk);
    cfg_we    = 1'b0;
  endtask

  task automatic commit();
    @(negedge aclk);
    cfg_commit = 1'b1;
    @(negedge aclk);
    cfg_commit = 1'b0;
  endtask

  task automatic clear_hist();
    @(negedge aclk);
    ctrl_clear = 1'b1;
    @(negedge aclk);
    ctrl_clear = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic run_beat(input string tag, input logic signed [15:0] d0, input logic signed [15:0] d1,
                          input logic last, input logic signed [15:0] e0, input logic signed [15:0] e1,
                          input int stall);
    int n;
    int lat;
    logic signed [15:0] g0, g1;
    @(negedge aclk);
    s_tdata  = {d0, d1};
    s_tlast  = last;
    s_tvalid = 1'b1;
    m_tready = (stall == 0);
    n = 0;
    while (!s_axis_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk({tag, "_accept"}, s_axis_tready, 1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    lat = 1;
    while (!m_axis_tvalid && lat < 50) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    chk({tag, "_tvalid"}, m_axis_tvalid, 1);
    chk({tag, "_lat"}, lat, 3);
    g0 = m_axis_tdata[31:16];
    g1 = m_axis_tdata[15:0];
    chk({tag, "_y0"}, g0, e0);
    chk({tag, "_y1"}, g1, e1);
    chk({tag, "_tlast"}, m_axis_tlast, last);
    for (int i = 0; i < stall; i++) begin
      @(posedge aclk);
      #1;
      g0 = m_axis_tdata[31:16];
      g1 = m_axis_tdata[15:0];
      chk({tag, "_hold_y0"}, g0, e0);
      chk({tag, "_hold_y1"}, g1, e1);
      chk({tag, "_hold_tlast"}, m_axis_tlast, last);
      chk({tag, "_hold_tvalid"}, m_axis_tvalid, 1);
      chk({tag, "_hold_sready"}, s_axis_tready, 0);
    end
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    chk({tag, "_done"}, m_axis_tvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic signed [15:0] g0, g1;
    aresetn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    ctrl_enable = 1'b1; ctrl_bypass = 1'b0; ctrl_clear = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_sat", sat_sticky, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_sready", s_axis_tready, 1);

    // Passthrough
    cfg_wr(0, 0, 16384);
    cfg_wr(1, 0, 16384);
    commit();
    chk("pass_pending", commit_pending, 1);
    run_beat("pass", 1000, -1000, 1'b0, 1000, -1000, 0);
    chk("pass_pending_clr", commit_pending, 0);

    // Recursion: ch0 y = (x + y1)/2
    clear_hist();
    cfg_wr(0, 0, 8192);
    cfg_wr(0, 2, 8192);
    commit();
    run_beat("rec1", 1000, 200, 1'b0, 500, 200, 0);
    run_beat("rec2", 1000, 200, 1'b0, 750, 200, 0);
    run_beat("rec3", 1000, 200, 1'b0, 875, 200, 0);

    // Saturation, then clear wipes sticky flag and history
    cfg_wr(0, 0, 32767);
    cfg_wr(0, 2, 0);
    cfg_wr(1, 0, 32767);
    commit();
    run_beat("sat", 30000, -30000, 1'b0, 32767, -32768, 0);
    chk("sat_sticky_set", sat_sticky, 1);
    clear_hist();
    chk("sat_sticky_clr", sat_sticky, 0);
    cfg_wr(0, 0, 0);
    cfg_wr(0, 1, 16384);
    commit();
    run_beat("postclr", 5, 5, 1'b0, 0, 9, 0);
    chk("postclr_sat", sat_sticky, 0);

    // Bypass leaves history alone
    ctrl_bypass = 1'b1;
    run_beat("byp", 1234, -7, 1'b0, 1234, -7, 0);
    ctrl_bypass = 1'b0;
    run_beat("postbyp", 100, 100, 1'b0, 5, 199, 0);

    // Atomic commit: shadow write in CALC, commit in OUT under backpressure
    @(negedge aclk);
    s_tdata = {16'sd40, 16'sd40}; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b0;
    chk("atom_accept", s_axis_tready, 1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    cfg_we = 1'b1; cfg_addr = {6'd1, 2'd0}; cfg_wdata = 16'sd16384;
    @(posedge aclk);
    #1;
    cfg_we = 1'b0;
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("atom_tvalid", m_axis_tvalid, 1);
    cfg_commit = 1'b1;
    @(posedge aclk);
    #1;
    cfg_commit = 1'b0;
    chk("atom_pending", commit_pending, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      chk("atom_hold_pending", commit_pending, 1);
      chk("atom_hold_tvalid", m_axis_tvalid, 1);
    end
    g0 = m_axis_tdata[31:16];
    g1 = m_axis_tdata[15:0];
    chk("atom_y0", g0, 100);
    chk("atom_y1", g1, 79);
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    chk("atom_idle_pending", commit_pending, 1);
    @(posedge aclk);
    #1;
    chk("atom_copied", commit_pending, 0);
    run_beat("atom_next", 8, 8, 1'b0, 40, 8, 0);

    // Backpressure with tlast
    run_beat("bp", 11, -11, 1'b1, 8, -11, 4);

    // Enable low blocks acceptance
    ctrl_enable = 1'b0;
    @(negedge aclk);
    chk("en_off_sready", s_axis_tready, 0);
    ctrl_enable = 1'b1;
    @(negedge aclk);
    chk("en_on_sready", s_axis_tready, 1);

    // Async reset in CALC
    @(negedge aclk);
    s_tdata = {16'sd3, 16'sd3}; s_tvalid = 1'b1; m_tready = 1'b1;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    cfg_commit = 1'b1;
    @(posedge aclk);
    #1;
    cfg_commit = 1'b0;
    chk("arst_pre_pending", commit_pending, 1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_pending", commit_pending, 0);
    chk("arst_sready", s_axis_tready, 0);
    chk("arst_tdata", m_axis_tdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    cfg_wr(0, 1, 16384);
    cfg_wr(1, 0, 16384);
    cfg_wr(1, 2, 16384);
    commit();
    run_beat("arst_after", 50, 60, 1'b0, 0, 60, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
